uart_tx_arbiter: RTL

//  Shares the single uart_basic transmitter between two requesters: req A (16-bit ALU result,

---
 rtl/uart_tx_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_basic transmitter between a word requester (A) and a byte requester (B).
// Latency: a request seen with the FSM idle and the UART idle gives tx_start 3 cycles after the req edge; ack in the cycle after the last tx_busy fall is seen.
// Backpressure: one holding slot per requester; a req while its slot is pending or its frame is in flight is dropped and sets sticky overflow.
module uart_tx_arbiter #(
  parameter int WORD_BYTES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [15:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [7:0]  b_data,
  output logic        b_ack,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        active,
  output logic        overflow,
  output logic        timeout
);

  // Rise-wait counter only needs to reach BUSY_TIMEOUT-1.
  localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [1:0]      A_LEN   = 2'(WORD_BYTES);
  localparam logic [1:0]      B_LEN   = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_DONE
  } state_t;

  state_t          state;
  logic            pend_a;
  logic            pend_b;
  logic [15:0]     a_hold_dat;
  logic [7:0]      b_hold_dat;
  logic            grant_b;        // frame owner: 0 = A, 1 = B
  logic            last_grant_b;   // owner of the most recently loaded frame
  logic [15:0]     shift_dat;      // current byte always sits in [7:0]
  logic [1:0]      byte_cnt;
  logic [TO_W-1:0] to_cnt;

  logic            in_frame;
  logic            a_blocked;
  logic            b_blocked;
  logic            a_take;
  logic            b_take;
  logic [1:0]      frame_len;
  logic            last_byte;
  logic            rise_expired;
  logic            byte_done;

  // A frame owns its requester from LOAD until the ack cycle; DONE is free so
  // a requester can re-arm in the same cycle its ack is seen.
  assign in_frame  = state inside {S_LOAD, S_START, S_WAIT_RISE, S_WAIT_FALL};
  assign a_blocked = pend_a | (in_frame & ~grant_b);
  assign b_blocked = pend_b | (in_frame &  grant_b);
  assign a_take    = a_req & ~a_blocked;
  assign b_take    = b_req & ~b_blocked;

  assign frame_len = grant_b ? B_LEN : A_LEN;
  assign last_byte = (byte_cnt + 2'd1) == frame_len;

  // A byte is finished when the UART drops busy, or when busy never showed up
  // within the timeout window (byte abandoned but counted as sent).
  assign rise_expired = (state == S_WAIT_RISE) && !tx_busy && (to_cnt == TO_LAST);
  assign byte_done    = rise_expired || ((state == S_WAIT_FALL) && !tx_busy);

  assign active = (state != S_IDLE);

  // Request latching into the 1-deep holding slots, overflow detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
      a_hold_dat <= '0;
      b_hold_dat <= '0;
      overflow   <= 1'b0;
    end else begin
      if (a_take) begin
        pend_a     <= 1'b1;
        a_hold_dat <= a_data;
      end else if ((state == S_LOAD) && !grant_b) begin
        pend_a <= 1'b0;
      end

      if (b_take) begin
        pend_b     <= 1'b1;
        b_hold_dat <= b_data;
      end else if ((state == S_LOAD) && grant_b) begin
        pend_b <= 1'b0;
      end

      if ((a_req && a_blocked) || (b_req && b_blocked)) begin
        overflow <= 1'b1;
      end
    end
  end

  // Arbitration and byte serialisation FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      grant_b      <= 1'b0;
      last_grant_b <= 1'b1;
      shift_dat    <= '0;
      byte_cnt     <= '0;
      to_cnt       <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pend_a && pend_b) begin
            grant_b <= ~last_grant_b;
            state   <= S_LOAD;
          end else if (pend_a) begin
            grant_b <= 1'b0;
            state   <= S_LOAD;
          end else if (pend_b) begin
            grant_b <= 1'b1;
            state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          shift_dat    <= grant_b ? {8'h00, b_hold_dat} : a_hold_dat;
          byte_cnt     <= '0;
          last_grant_b <= grant_b;
          state        <= S_START;
        end

        S_START: begin
          // Never hand a byte to a transmitter that is still busy.
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= shift_dat[7:0];
            to_cnt   <= '0;
            state    <= S_WAIT_RISE;
          end
        end

        S_WAIT_RISE: begin
          if (tx_busy) begin
            state <= S_WAIT_FALL;
          end else if (rise_expired) begin
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end

        S_WAIT_FALL: begin
          // Byte advance on busy fall is handled below, shared with timeout.
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      if (byte_done) begin
        byte_cnt  <= byte_cnt + 2'd1;
        shift_dat <= {8'h00, shift_dat[15:8]};
        if (last_byte) begin
          state <= S_DONE;
          if (grant_b) begin
            b_ack <= 1'b1;
          end else begin
            a_ack <= 1'b1;
          end
        end else begin
          state <= S_START;
        end
      end
    end
  end

endmodule
